frame_program_port: RTL and testbench

// - Receiving end of the pixel program bus driven by the graphic copy engines.
// - Accepts one pixel write per cycle: program_x, program_y, program_data, program_write.
// - Clips each pixel to 640x480 and converts it to a linear frame-buffer address in the selected draw buffer.
// - Buffers writes in a FIFO and issues them to the SRAM controller with a valid/ready handshake.
// - Sits between the copy engines and the SRAM controller, which interleaves these writes with VGA reads.

---
 rtl/boxhead_fb_pkg.sv | 24 ++
 rtl/fb_sync_fifo.sv | 53 +++++
 rtl/frame_program_port.sv | 103 ++++++++++
 tb/tb_frame_program_port.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/boxhead_fb_pkg.sv
// Shared frame-buffer types and constants for the copy engines and program port.
package boxhead_fb_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FB_ADDR_W = 20;

  // Colour the copy engines treat as "do not draw".
  localparam logic [15:0] TRANSPARENT_COLOR = 16'h07E0;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    fb_addr_t    addr;
    logic [15:0] data;
  } fb_write_t;

  // Linear pixel offset y*640+x built from shifts and adds (640 = 512 + 128),
  // so no multiplier is inferred. Fits 19 bits for any on-screen pixel.
  function automatic logic [18:0] pixel_offset(input logic [9:0] x, input logic [9:0] y);
    return {y, 9'd0} + {2'd0, y, 7'd0} + {9'd0, x};
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra MSB so
// that a full FIFO (level == Depth) and an empty one (level == 0) differ.
// A push while full succeeds only if a pop happens in the same cycle.
module fb_sync_fifo #(
  parameter int Width = 36,
  parameter int Depth = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int PW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[PW-1:0]] <= push_data;
    end
  end

  // Read/write pointers, wrapping modulo Depth in their low bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  assign level = wptr - rptr;
  assign full  = (level == (PW+1)'(Depth));
  assign empty = (level == '0);
  assign head  = mem[rptr[PW-1:0]];

endmodule

// File: rtl/frame_program_port.sv
// Receiving end of the pixel program bus. Clips each pixel to the screen,
// turns it into a linear frame-buffer address in the selected draw buffer,
// queues it and hands it to the SRAM controller.
//
// Handshake (SRAM side): wr_valid/wr_addr/wr_data describe the oldest queued
// write; the entry transfers on a cycle where wr_valid && wr_ready, and while
// wr_valid=1 with wr_ready=0 the address and data are held unchanged. The
// source side has no backpressure: a pixel that finds the FIFO full (and no
// transfer that same cycle) is dropped and flagged in the sticky overflow bit.
module frame_program_port
  import boxhead_fb_pkg::*;
#(
  parameter int FifoDepth = 16,
  parameter int AddrWidth = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [9:0]                  program_x,
  input  logic [9:0]                  program_y,
  input  logic [15:0]                 program_data,
  input  logic                        program_write,
  input  logic                        draw_buffer,
  input  logic                        overflow_clear,
  output logic                        wr_valid,
  output logic [AddrWidth-1:0]        wr_addr,
  output logic [15:0]                 wr_data,
  input  logic                        wr_ready,
  output logic                        idle,
  output logic [$clog2(FifoDepth):0]  fifo_level,
  output logic                        overflow
);

  logic      in_range;
  logic      accept;
  logic      stage_valid;
  fb_write_t stage_entry;
  fb_write_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;
  logic      drop;

  assign in_range = (program_x < 10'(SCREEN_W)) && (program_y < 10'(SCREEN_H));
  assign accept   = program_write && in_range;

  // Stage 1: register the clipped pixel with its address; buffer bit on top.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_entry <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_entry.addr <= {draw_buffer, pixel_offset(program_x, program_y)};
        stage_entry.data <= program_data;
      end
    end
  end

  assign pop  = wr_valid && wr_ready;
  assign drop = stage_valid && fifo_full && !pop;

  // Stage 2: the FIFO takes the staged entry unless it is full with no pop.
  fb_sync_fifo #(
    .Width ($bits(fb_write_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (stage_valid),
    .push_data (stage_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Sticky drop flag; a drop in the same cycle beats a clear request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  // Head presentation is forced to zero while empty so stale storage never shows.
  always_comb begin
    wr_valid = !fifo_empty;
    wr_addr  = '0;
    wr_data  = '0;
    if (!fifo_empty) begin
      wr_addr = AddrWidth'(head.addr);
      wr_data = head.data;
    end
  end

  assign idle = !stage_valid && fifo_empty;

endmodule

// File: tb/tb_frame_program_port.sv
// Bench for frame_program_port: directed scenarios followed by a random phase,
// all checked every cycle against a queue-based reference of the port.
module tb_frame_program_port;

  localparam int DEPTH = 16;
  localparam int AW    = 20;
  localparam int LVW   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [9:0]     program_x;
  logic [9:0]     program_y;
  logic [15:0]    program_data;
  logic           program_write;
  logic           draw_buffer;
  logic           overflow_clear;
  logic           wr_valid;
  logic [AW-1:0]  wr_addr;
  logic [15:0]    wr_data;
  logic           wr_ready;
  logic           idle;
  logic [LVW-1:0] fifo_level;
  logic           overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: queued writes as {addr, data}, plus the staged pixel.
  logic [AW+15:0] exp_q[$];
  logic           pend_v;
  logic [AW+15:0] pend;
  logic           m_ovf;

  // Clock: 50 MHz.
  always #10 clk = ~clk;

  frame_program_port #(.FifoDepth(DEPTH), .AddrWidth(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .program_x      (program_x),
    .program_y      (program_y),
    .program_data   (program_data),
    .program_write  (program_write),
    .draw_buffer    (draw_buffer),
    .overflow_clear (overflow_clear),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .idle           (idle),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what one clock edge does to the port, stated from its rules.
  task automatic model_edge();
    bit pop;
    bit drop;
    int a;
    if (!reset_n) begin
      exp_q.delete();
      pend_v = 1'b0;
      pend   = '0;
      m_ovf  = 1'b0;
    end else begin
      pop  = (exp_q.size() > 0) && wr_ready;
      drop = 1'b0;
      if (pop) void'(exp_q.pop_front());
      if (pend_v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pend);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clear) m_ovf = 1'b0;
      pend_v = program_write && (program_x < 640) && (program_y < 480);
      a = int'(draw_buffer) * (1 << 19) + int'(program_y) * 640 + int'(program_x);
      pend = {AW'(a), program_data};
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("wr_valid", 32'(wr_valid), 32'(exp_q.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("idle", 32'(idle), 32'(!pend_v && exp_q.size() == 0));
    if (exp_q.size() != 0) begin
      chk("wr_addr", 32'(wr_addr), 32'(exp_q[0][AW+15:16]));
      chk("wr_data", 32'(wr_data), 32'(exp_q[0][15:0]));
    end
  endtask

  // Driver: present one pixel for one cycle, then release the bus.
  task automatic pixel(input int x, input int y, input logic [15:0] d, input logic b);
    program_x     = 10'(x);
    program_y     = 10'(y);
    program_data  = d;
    draw_buffer   = b;
    program_write = 1'b1;
    cycle();
    program_write = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    reset_n        = 1'b0;
    program_x      = '0;
    program_y      = '0;
    program_data   = '0;
    program_write  = 1'b0;
    draw_buffer    = 1'b0;
    overflow_clear = 1'b0;
    wr_ready       = 1'b1;
    pend_v         = 1'b0;
    pend           = '0;
    m_ovf          = 1'b0;

    // Reset state.
    wait_cycles(2);
    check_reset_state("reset");
    reset_n = 1'b1;
    cycle();

    // Single pixel: valid two cycles after presentation, idle one after that.
    pixel(3, 2, 16'hF800, 1'b0);
    cycle();
    chk("single_valid", 32'(wr_valid), 32'd1);
    chk("single_addr", 32'(wr_addr), 32'h00503);
    chk("single_data", 32'(wr_data), 32'hF800);
    cycle();
    chk("single_idle", 32'(idle), 32'd1);

    // Corner pixel in buffer 1.
    pixel(639, 479, 16'h1234, 1'b1);
    cycle();
    chk("corner_addr", 32'(wr_addr), 32'h0CAFFF);
    wait_cycles(2);

    // Clipping: nothing enters.
    pixel(640, 0, 16'hAAAA, 1'b0);
    chk("clip_x_idle", 32'(idle), 32'd1);
    pixel(0, 480, 16'h5555, 1'b0);
    chk("clip_y_idle", 32'(idle), 32'd1);
    wait_cycles(3);
    chk("clip_level", 32'(fifo_level), 32'd0);
    chk("clip_ovf", 32'(overflow), 32'd0);

    // Backpressure burst of 20 into a 16-deep FIFO.
    wr_ready = 1'b0;
    for (int i = 0; i < 20; i++) pixel(i * 7, i + 10, 16'(16'h0100 + i), i[0]);
    cycle();
    chk("bp_level", 32'(fifo_level), 32'd16);
    chk("bp_ovf", 32'(overflow), 32'd1);
    wr_ready = 1'b1;
    wait_cycles(18);
    chk("bp_drained", 32'(idle), 32'd1);
    overflow_clear = 1'b1;
    cycle();
    overflow_clear = 1'b0;
    chk("bp_cleared", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous pop: no drop, level holds at 16.
    wr_ready = 1'b0;
    for (int i = 0; i < 17; i++) pixel(100 + i, 200, 16'(16'h2000 + i), 1'b0);
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pixel(300 + i, 300, 16'(16'h3000 + i), 1'b1);
      chk("full_pop_level", 32'(fifo_level), 32'd16);
      chk("full_pop_ovf", 32'(overflow), 32'd0);
    end
    wr_ready = 1'b0;
    wait_cycles(3);
    wr_ready = 1'b1;
    wait_cycles(20);

    // Reset with 8 entries queued, then a fresh pixel.
    wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) pixel(i, i, 16'(16'h4000 + i), 1'b0);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_reset_state("midreset");
    wr_ready = 1'b1;
    pixel(10, 1, 16'hBEEF, 1'b1);
    cycle();
    chk("post_reset_addr", 32'(wr_addr), 32'h8028A);
    wait_cycles(2);

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      program_write  = ($urandom_range(0, 99) < 70);
      program_x      = 10'($urandom_range(0, 700));
      program_y      = 10'($urandom_range(0, 520));
      program_data   = 16'($urandom);
      draw_buffer    = 1'($urandom);
      wr_ready       = ($urandom_range(0, 99) < 55);
      overflow_clear = ($urandom_range(0, 99) < 5);
      cycle();
    end
    program_write  = 1'b0;
    overflow_clear = 1'b0;
    wr_ready       = 1'b1;
    wait_cycles(20);
    chk("final_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
